regbank_dumper: RTL and testbench
=================================

// Module: regbank_dumper
// PURPOSE
//   Read-side counterpart to the counter-driven RegBank write path.
//   Sweeps an address range of the RegBank through its two read ports (a, b).
//   Fetches up to two registers per clock.
//   Streams each word out with its address over a valid/ready handshake, so a
//   bench or debug sink can dump bank contents after a write pass.
// PARAMETERS
//   ADDR_W  5   register address width (bank depth = 2**ADDR_W = 32)
//   DATA_W  64  register data width
//   FIFO_D  4   output buffer depth in words (power of two, >= 2)
// PORTS
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous, active-low reset
//   start      in   1       begin a dump; sampled only in IDLE
//   first      in   ADDR_W  first address of range; captured on accepted start
//   last       in   ADDR_W  last address of range, inclusive; captured on start
//   rd_addr_a  out  ADDR_W  to RegBank read port a
//   rd_addr_b  out  ADDR_W  to RegBank read port b
//   rd_data_a  in   DATA_W  RegBank dataA (combinational read of rd_addr_a)
//   rd_data_b  in   DATA_W  RegBank dataB (combinational read of rd_addr_b)
//   out_valid  out  1       out_data/out_addr/out_last hold a word
//   out_ready  in   1       sink accepts the word this cycle
//   out_data   out  DATA_W  register contents
//   out_addr   out  ADDR_W  address the word was read from
//   out_last   out  1       word is the final one of the range
//   busy       out  1       dump in progress
//   done       out  1       one-cycle pulse after final word handshake
// BEHAVIOUR
//   - Reset (reset=0, async): state IDLE.
//     - All outputs 0: rd_addr_a/b=0, out_valid=0, out_data=0, out_addr=0,
//       out_last=0, busy=0, done=0.
//     - FIFO emptied; in-flight dump abandoned, no done pulse.
//   - Range length N = ((last - first) mod 32) + 1, 6-bit, 1..32.
//     - last < first wraps through 31 -> 0.
//     - first == last dumps exactly one word.
//   - FSM states:
//     - IDLE: start=1 captures first/last, sets ptr=first and rem=N, then
//       goes to FETCH. busy=1 from the next cycle.
//     - FETCH: each cycle, rd_addr_a=ptr and rd_addr_b=ptr+1 (mod 32).
//       - rem>=2 and >=2 free FIFO slots: push (ptr,data_a) then
//         (ptr+1,data_b); ptr+=2, rem-=2.
//       - rem==1 and >=1 free slot: push (ptr,data_a) only; rem=0.
//       - Not enough space: no push; ptr and rem held.
//       - rem reaching 0 moves to DRAIN.
//     - DRAIN: FIFO empties via handshakes. The final word's handshake moves to
//       DONE.
//     - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
//   - Entry tagged last when pushed with rem==1 (single) or rem==2 (second of
//     pair).
//   - Data read same cycle as address (combinational RegBank read); no read
//     latency.
//   - Handshake: word transfers on rising edge with out_valid & out_ready.
//     - While out_valid=1 and out_ready=0, out_data/addr/last are stable.
//     - out_valid never drops without a transfer.
//   - Output is FIFO head, registered. The first word appears one cycle after
//     its fetch.
//     - Push and pop may occur in the same cycle.
//     - Free-slot count for a push uses occupancy before this cycle's pop.
//   - Throughput: one word per cycle with out_ready held 1.
//   - Words emerge in address order first, first+1, ... mod 32.
//   - start while busy or in DONE: ignored.
//   - rd_addr_a/b hold their last values in IDLE, DRAIN and DONE.
//   - Arithmetic: ptr, addresses mod 2**ADDR_W; rem 6 bits; FIFO pointers
//     log2(FIFO_D)+1 bits.
// TESTING
//   - Bank[i]=i for all i; start, first=0, last=31, out_ready=1:
//     - 32 words, addr=data=0..31, out_last only on addr 31.
//     - done pulses once, busy back to 0.
//   - first=5, last=5: exactly one word (addr 5, data 5, out_last=1); done
//     next cycle after handshake.
//   - Wrap: first=30, last=1: words addr 30,31,0,1 in order; out_last on
//     addr 1; N=4.
//   - Backpressure: out_ready=0 for 10 cycles mid-dump:
//     - out_data/addr frozen, FIFO holds <=FIFO_D words.
//     - No word lost or duplicated after release.
//   - Async reset asserted mid-dump (after 7 words): outputs 0 immediately,
//     no done.
//     - A new start, first=0, last=3, dumps 4 fresh words.
//   - start pulsed while busy with different first/last: ignored; original
//     range completes unchanged.

Source files
------------

// File: rtl/regbank_dumper.sv
// regbank_dumper
//   Sweeps an inclusive, wrapping address range of a RegBank through its two
//   combinational read ports, fetching up to two words per clock, and streams
//   each word with its address over a valid/ready handshake.
//
//   Parameters: ADDR_W (address width), DATA_W (word width),
//               FIFO_D (output buffer depth, power of two, >= 2)
//   Ports:
//     clk, reset (async, active-low)
//     start, first, last          : dump request and inclusive range
//     rd_addr_a/b, rd_data_a/b    : RegBank read ports a and b
//     out_valid/out_ready         : output handshake
//     out_data/out_addr/out_last  : word, its address, final-word tag
//     busy, done                  : dump in progress / one-cycle completion
module regbank_dumper #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned FIFO_D = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] first,
   input  logic [ADDR_W-1:0] last,
   output logic [ADDR_W-1:0] rd_addr_a,
   output logic [ADDR_W-1:0] rd_addr_b,
   input  logic [DATA_W-1:0] rd_data_a,
   input  logic [DATA_W-1:0] rd_data_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   localparam int unsigned PW = $clog2(FIFO_D);
   localparam int unsigned RW = ADDR_W + 1;

   localparam logic [PW:0]       F_ONE  = (PW+1)'(1);
   localparam logic [PW:0]       F_TWO  = (PW+1)'(2);
   localparam logic [PW:0]       F_DEP  = (PW+1)'(FIFO_D);
   localparam logic [PW-1:0]     I_ONE  = PW'(1);
   localparam logic [RW-1:0]     R_ONE  = RW'(1);
   localparam logic [RW-1:0]     R_TWO  = RW'(2);
   localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_TWO  = ADDR_W'(2);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] ptr_a_q;
   logic [ADDR_W-1:0] ptr_b_q;
   logic [RW-1:0]     rem_q;
   logic              busy_q;
   logic              done_q;

   logic [DATA_W-1:0] fifo_data_q [FIFO_D];
   logic [ADDR_W-1:0] fifo_addr_q [FIFO_D];
   logic              fifo_last_q [FIFO_D];
   logic [PW:0]       wr_q;
   logic [PW:0]       rd_q;

   logic [PW:0]       count;
   logic [PW:0]       free;
   logic [PW-1:0]     wr_idx1;
   logic [ADDR_W-1:0] span;
   logic [RW-1:0]     range_n;
   logic              pop;
   logic              push_pair;
   logic              push_one;
   logic              final_pair;

   always_comb begin
      count      = wr_q - rd_q;
      // Space is judged on occupancy before this cycle's pop.
      free       = F_DEP - count;
      wr_idx1    = wr_q[PW-1:0] + I_ONE;
      span       = last - first;
      range_n    = {1'b0, span} + R_ONE;
      pop        = (count != '0) && out_ready;
      push_pair  = (state_q == S_FETCH) && (rem_q >= R_TWO) && (free >= F_TWO);
      push_one   = (state_q == S_FETCH) && (rem_q == R_ONE) && (free >= F_ONE);
      final_pair = (rem_q == R_TWO);
   end

   // The read pointers double as the read-port addresses; they are not
   // advanced on the final push so the ports hold once fetching ends.
   assign rd_addr_a = ptr_a_q;
   assign rd_addr_b = ptr_b_q;
   assign out_valid = (count != '0);
   assign out_data  = fifo_data_q[rd_q[PW-1:0]];
   assign out_addr  = fifo_addr_q[rd_q[PW-1:0]];
   assign out_last  = fifo_last_q[rd_q[PW-1:0]];
   assign busy      = busy_q;
   assign done      = done_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         ptr_a_q <= '0;
         ptr_b_q <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         for (int unsigned i = 0; i < FIFO_D; i++) begin
            fifo_data_q[i] <= '0;
            fifo_addr_q[i] <= '0;
            fifo_last_q[i] <= 1'b0;
         end
      end else begin
         if (pop) begin
            rd_q <= rd_q + F_ONE;
         end

         if (push_pair) begin
            fifo_data_q[wr_q[PW-1:0]] <= rd_data_a;
            fifo_addr_q[wr_q[PW-1:0]] <= ptr_a_q;
            fifo_last_q[wr_q[PW-1:0]] <= 1'b0;
            fifo_data_q[wr_idx1]      <= rd_data_b;
            fifo_addr_q[wr_idx1]      <= ptr_b_q;
            fifo_last_q[wr_idx1]      <= final_pair;
            wr_q                      <= wr_q + F_TWO;
         end else if (push_one) begin
            fifo_data_q[wr_q[PW-1:0]] <= rd_data_a;
            fifo_addr_q[wr_q[PW-1:0]] <= ptr_a_q;
            fifo_last_q[wr_q[PW-1:0]] <= 1'b1;
            wr_q                      <= wr_q + F_ONE;
         end

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  ptr_a_q <= first;
                  ptr_b_q <= first + A_ONE;
                  rem_q   <= range_n;
                  busy_q  <= 1'b1;
                  state_q <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (push_pair) begin
                  rem_q <= rem_q - R_TWO;
                  if (final_pair) begin
                     state_q <= S_DRAIN;
                  end else begin
                     ptr_a_q <= ptr_a_q + A_TWO;
                     ptr_b_q <= ptr_b_q + A_TWO;
                  end
               end else if (push_one) begin
                  rem_q   <= '0;
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (pop && (count == F_ONE)) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regbank_dumper.sv
module tb_regbank_dumper;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [4:0]  first;
   logic [4:0]  last;
   logic [4:0]  rd_addr_a;
   logic [4:0]  rd_addr_b;
   logic [63:0] rd_data_a;
   logic [63:0] rd_data_b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [4:0]  out_addr;
   logic        out_last;
   logic        busy;
   logic        done;

   logic [63:0] bank [32];

   int tests = 0;
   int fails = 0;

   regbank_dumper #(.ADDR_W(5), .DATA_W(64), .FIFO_D(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .first     (first),
      .last      (last),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_addr  (out_addr),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   // Combinational RegBank read model.
   assign rd_data_a = bank[rd_addr_a];
   assign rd_data_b = bank[rd_addr_b];

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1);
   end

   typedef struct {
      logic [4:0] f;
      logic [4:0] l;
      int         n;          // hand-computed range length
      int         stall_at;   // words accepted before the stall begins
      int         stall_len;  // cycles of out_ready=0 (0 = none)
      bit         inj;        // pulse start with another range while busy
      bit         pat;        // use tagged bank contents instead of bank[i]=i
      bit         dstart;     // pulse start during the DONE cycle
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_rd_addr_a"}, 64'(rd_addr_a), 64'd0);
      check({tag, "_rd_addr_b"}, 64'(rd_addr_b), 64'd0);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_out_data"},  out_data,       64'd0);
      check({tag, "_out_addr"},  64'(out_addr),  64'd0);
      check({tag, "_out_last"},  64'(out_last),  64'd0);
      check({tag, "_busy"},      64'(busy),      64'd0);
      check({tag, "_done"},      64'(done),      64'd0);
   endtask

   task automatic fill_bank(input bit pat);
      for (int i = 0; i < 32; i++)
         bank[i] = pat ? (64'hC0DE_0000_0000_0000 | 64'(i)) : 64'(i);
   endtask

   // Runs one dump from IDLE; called at a negedge, returns at a negedge in IDLE.
   task automatic run_dump(input vec_t v);
      int          got = 0;
      int          stall = 0;
      int          cyc = 0;
      int          first_hs = -1;
      int          last_hs = -1;
      bit          fin = 0;
      bit          held = 0;
      bit          injected = 0;
      bit          ended = 0;
      logic [63:0] pd = '0;
      logic [4:0]  pa = '0;
      logic        pl = 1'b0;
      logic [4:0]  ea;

      fill_bank(v.pat);
      start = 1'b1; first = v.f; last = v.l; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 64'(busy), 64'd1);
      // Live range inputs now differ; the captured range must be used.
      first = ~v.f; last = ~v.l;

      while (cyc < 300) begin
         if (fin) begin
            check("done_pulse",    64'(done),      64'd1);
            check("busy_at_done",  64'(busy),      64'd0);
            check("valid_at_done", 64'(out_valid), 64'd0);
            ended = 1;
            break;
         end
         check("no_early_done", 64'(done), 64'd0);
         if (held) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data",  out_data,       pd);
            check("hold_addr",  64'(out_addr),  64'(pa));
            check("hold_last",  64'(out_last),  64'(pl));
         end
         start = 1'b0;
         if (v.inj && got == 3 && !injected) begin
            start = 1'b1; first = 5'd20; last = 5'd22; injected = 1;
         end
         if (v.stall_len > 0 && got == v.stall_at && stall < v.stall_len) begin
            out_ready = 1'b0;
            stall++;
         end else begin
            out_ready = 1'b1;
         end
         held = out_valid && !out_ready;
         pa = out_addr; pd = out_data; pl = out_last;
         if (out_valid && out_ready) begin
            ea = v.f + 5'(got);
            check("word_addr", 64'(out_addr), 64'(ea));
            check("word_data", out_data,      bank[ea]);
            check("word_last", 64'(out_last), 64'(got == v.n - 1));
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            got++;
            if (got == v.n) fin = 1;
         end
         @(negedge clk);
         cyc++;
      end

      check("dump_completed", 64'(ended), 64'd1);
      check("word_count",     64'(got),   64'(v.n));
      check("first_latency",  64'(first_hs), 64'd1);
      if (v.stall_len == 0)
         check("throughput", 64'(last_hs - first_hs), 64'(v.n - 1));

      start = v.dstart;
      first = 5'd0; last = 5'd0;
      @(negedge clk);
      start = 1'b0;
      check("done_one_cycle", 64'(done),      64'd0);
      check("idle_busy",      64'(busy),      64'd0);
      check("idle_valid",     64'(out_valid), 64'd0);
      @(negedge clk);
      check("idle_busy2",     64'(busy),      64'd0);
   endtask

   vec_t vecs [8];

   initial begin
      int got;
      int cyc;
      bit seen_done;

      vecs[0] = '{5'd0,  5'd31, 32, 0, 0,  1'b0, 1'b0, 1'b0};
      vecs[1] = '{5'd5,  5'd5,  1,  0, 0,  1'b0, 1'b0, 1'b0};
      vecs[2] = '{5'd30, 5'd1,  4,  0, 0,  1'b0, 1'b0, 1'b0};
      vecs[3] = '{5'd3,  5'd20, 18, 6, 10, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{5'd10, 5'd17, 8,  0, 0,  1'b1, 1'b0, 1'b0};
      vecs[5] = '{5'd31, 5'd0,  2,  0, 0,  1'b0, 1'b1, 1'b1};
      vecs[6] = '{5'd7,  5'd6,  32, 0, 0,  1'b0, 1'b1, 1'b0};
      vecs[7] = '{5'd12, 5'd14, 3,  1, 4,  1'b0, 1'b0, 1'b0};

      fill_bank(1'b0);
      reset = 1'b1; start = 1'b0; first = '0; last = '0; out_ready = 1'b1;
      #3 reset = 1'b0;
      #1 check_idle_zero("reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_idle_zero("post_reset");

      for (int i = 0; i < 8; i++)
         run_dump(vecs[i]);

      // Asynchronous reset mid-dump after seven words.
      fill_bank(1'b0);
      start = 1'b1; first = 5'd0; last = 5'd31; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      got = 0; cyc = 0;
      while (got < 7 && cyc < 50) begin
         if (out_valid && out_ready) got++;
         @(negedge clk);
         cyc++;
      end
      check("words_before_reset", 64'(got), 64'd7);
      check("busy_before_reset",  64'(busy), 64'd1);
      #2 reset = 1'b0;
      #1 check_idle_zero("async_reset");
      seen_done = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 2) reset = 1'b1;
         seen_done |= done;
      end
      check("no_done_after_abort", 64'(seen_done), 64'd0);
      check_idle_zero("after_abort");
      run_dump('{5'd0, 5'd3, 4, 0, 0, 1'b0, 1'b0, 1'b0});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
